// File: rtl/sprite_sched_pkg.sv
// -----------------------------------------------------------------------------
// sprite_sched_pkg
// Shared types and constants for the vblank-synchronised sprite register write
// scheduler: scheduler state encoding, the sprite engine register map and the
// layout of one queued write (address + data = 22 bits).
// -----------------------------------------------------------------------------
package sprite_sched_pkg;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 16;
    localparam int ENTRY_W = ADDR_W + DATA_W;  // 22

    // Scheduler state: IDLE collects writes, DRAIN replays them inside vsync.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } sched_state_e;

    // One queued engine register write. Address sits in the upper bits.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sched_entry_t;

    // Sprite engine register map (even addresses only).
    localparam logic [ADDR_W-1:0] SPR0_POS  = 6'h04;
    localparam logic [ADDR_W-1:0] SPR0_BMP0 = 6'h06;
    localparam logic [ADDR_W-1:0] SPR0_BMP1 = 6'h08;
    localparam logic [ADDR_W-1:0] SPR0_BMP2 = 6'h0A;
    localparam logic [ADDR_W-1:0] SPR0_BMP3 = 6'h0C;
    localparam logic [ADDR_W-1:0] SPR1_POS  = 6'h0E;
    localparam logic [ADDR_W-1:0] SPR1_BMP0 = 6'h10;
    localparam logic [ADDR_W-1:0] SPR1_BMP1 = 6'h12;
    localparam logic [ADDR_W-1:0] SPR1_BMP2 = 6'h14;
    localparam logic [ADDR_W-1:0] SPR1_BMP3 = 6'h16;

endpackage

// File: rtl/sprite_req_fifo.sv
// -----------------------------------------------------------------------------
// sprite_req_fifo
// Synchronous FIFO holding queued engine register writes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full or flushing)
//   push_data   : entry to enqueue
//   pop         : drop the head entry (ignored when empty or flushing)
//   flush       : discard all entries; overrides push and pop
//   head        : current head entry (valid when !empty)
//   full, empty : occupancy flags
//   level       : number of stored entries, 0..DEPTH
// Pointers are $clog2(DEPTH) bits plus one wrap bit, so occupancy is the plain
// difference of the extended pointers (DEPTH must be a power of two, >= 2).
// -----------------------------------------------------------------------------
module sprite_req_fifo
    import sprite_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_cnt;   // {wrap, ptr}
    logic [AW:0]      rd_cnt;   // {wrap, ptr}
    logic             do_push;
    logic             do_pop;

    assign level   = wr_cnt - rd_cnt;
    assign empty   = (wr_cnt == rd_cnt);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_cnt[AW-1:0]];

    // NOTE: storage has no reset; emptiness is tracked by the pointers alone,
    // so resetting the array would only cost flops without changing behaviour.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_cnt[AW-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (flush) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (do_push) wr_cnt <= wr_cnt + 1'b1;
            if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_update_sched.sv
// -----------------------------------------------------------------------------
// sprite_update_sched
// Queues CPU writes to sprite engine registers and replays them onto the
// engine register port only during the vsync window, so on-screen changes never
// tear mid-frame. Raises a sticky irq when a frame's batch has been committed.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : CPU write handshake (req_ready = !full)
//   req_addr, req_data  : engine register address / data
//   vsync               : engine vsync (same clock domain)
//   flush               : discard queued writes, return to IDLE
//   irq_clr, ovf_clr    : clear the sticky irq / overflow flags
//   eng_wr_en/addr/data : registered write slot towards the engine
//   eng_wr_ready        : engine accepts the slot when eng_wr_en is high
//   level               : FIFO occupancy
//   overflow            : sticky, a request was refused because FIFO was full
//   irq                 : sticky, a drain window finished (not via flush)
// -----------------------------------------------------------------------------
module sprite_update_sched
    import sprite_sched_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int MAX_PER_FRAME = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [5:0]               req_addr,
    input  logic [15:0]              req_data,
    input  logic                     vsync,
    input  logic                     flush,
    input  logic                     irq_clr,
    input  logic                     ovf_clr,
    output logic                     eng_wr_en,
    output logic [5:0]               eng_addr,
    output logic [15:0]              eng_data,
    input  logic                     eng_wr_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     irq
);

    localparam logic [7:0] MAX_B = 8'(MAX_PER_FRAME);

    sched_state_e   state;
    sched_state_e   state_next;
    logic           vsync_q;
    logic           vsync_rise;
    logic [7:0]     budget;
    logic [7:0]     budget_inc;
    logic           drain_done;

    logic           fifo_full;
    logic           fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    sched_entry_t   head_entry;
    logic           push;
    logic           pop;
    logic           slot_free;

    assign req_ready  = !fifo_full;
    assign vsync_rise = vsync && !vsync_q;
    assign head_entry = sched_entry_t'(fifo_head);

    // The slot can take a new entry if it is empty or being accepted right now.
    assign slot_free  = !eng_wr_en || eng_wr_ready;
    assign push       = req_valid && req_ready && !flush;
    assign pop        = (state == DRAIN) && !fifo_empty && slot_free && !flush;
    assign budget_inc = budget + {7'd0, pop};

    sprite_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({req_addr, req_data}),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_next;
            vsync_q <= vsync;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (vsync_rise && !flush) state_next = DRAIN;
            end
            DRAIN: begin
                if (flush) begin
                    // Flush aborts the window silently: no completion irq.
                    state_next = IDLE;
                end else if ((fifo_empty && !pop) || (budget_inc == MAX_B) || !vsync) begin
                    // Budget exit fires on the pop that reaches the limit, so
                    // no further pop is attempted in this window.
                    state_next = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- budget counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            budget <= '0;
        end else if (state == IDLE && vsync_rise) begin
            budget <= '0;
        end else if (pop) begin
            budget <= budget_inc;
        end
    end

    // ---------------- output slot ----------------
    // A loaded slot is always completed; neither flush nor leaving DRAIN
    // cancels it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_wr_en <= 1'b0;
            eng_addr  <= '0;
            eng_data  <= '0;
        end else if (pop) begin
            eng_wr_en <= 1'b1;
            eng_addr  <= head_entry.addr;
            eng_data  <= head_entry.data;
        end else if (eng_wr_en && eng_wr_ready) begin
            eng_wr_en <= 1'b0;
        end
    end

    // ---------------- sticky flags (set wins over clear) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (drain_done)                  irq <= 1'b1;
            else if (irq_clr)                irq <= 1'b0;
            if (req_valid && !req_ready)     overflow <= 1'b1;
            else if (ovf_clr)                overflow <= 1'b0;
        end
    end

endmodule
